// File: rtl/sqrt_multi_cycle_hs_if.sv
// Handshake bundle for sqrt_multi_cycle_hs: radicand in (arg_*), root/remainder out (res_*).
// master drives the radicand and result-ready; slave is the square-root block.
interface sqrt_multi_cycle_hs_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                    arg_vld;
    logic                    arg_rdy;
    logic [DATA_WIDTH-1:0]   arg;
    logic                    res_vld;
    logic                    res_rdy;
    logic [DATA_WIDTH/2-1:0] res;
    logic [DATA_WIDTH/2:0]   rem;
    logic                    busy;

    modport master (
        output arg_vld,
        output arg,
        output res_rdy,
        input  arg_rdy,
        input  res_vld,
        input  res,
        input  rem,
        input  busy
    );

    modport slave (
        input  arg_vld,
        input  arg,
        input  res_rdy,
        output arg_rdy,
        output res_vld,
        output res,
        output rem,
        output busy
    );
endinterface

// File: rtl/sqrt_multi_cycle_hs.sv
// Multi-cycle restoring integer square root, one root bit per clock, valid/ready on both sides.
// Define SQRT_ROUND_NEAREST_EN to round res to nearest (saturating); rem stays the floor remainder.
module sqrt_multi_cycle_hs #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sqrt_multi_cycle_hs_if.slave bus
);
    localparam int unsigned HalfW = DATA_WIDTH / 2;
    localparam int unsigned RemW  = HalfW + 2;
    localparam int unsigned CntW  = $clog2(HalfW + 1);

    if (((DATA_WIDTH % 2) != 0) || (DATA_WIDTH < 4)) begin : gen_bad_width
        $error("sqrt_multi_cycle_hs: DATA_WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rad_q, rad_d;
    logic [RemW-1:0]       rem_q, rem_d;
    logic [HalfW-1:0]      root_q, root_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    // One extra bit above the remainder width so the borrow of the trial subtraction is visible.
    logic [RemW:0] shifted;
    logic [RemW:0] subtrahend;
    logic [RemW:0] trial;
    logic          trial_ok;

    assign shifted    = {rem_q[RemW-2:0], rad_q[DATA_WIDTH-1 -: 2]};
    assign subtrahend = {1'b0, root_q, 2'b01};
    assign trial      = shifted - subtrahend;
    assign trial_ok   = ~trial[RemW];

    // The remainder never exceeds 2*root, so these high bits are structurally zero.
    logic unused_high_bits;
    assign unused_high_bits = ^{rem_q[RemW-1], shifted[RemW]};

    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.arg_vld) begin
                    rad_d   = bus.arg;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CntW'(HalfW);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                rad_d  = {rad_q[DATA_WIDTH-3:0], 2'b00};
                rem_d  = trial_ok ? trial[RemW-1:0] : shifted[RemW-1:0];
                root_d = {root_q[HalfW-2:0], trial_ok};
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.res_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.arg_rdy = (state_q == StIdle);
    assign bus.res_vld = (state_q == StDone);
    assign bus.busy    = (state_q != StIdle);
    assign bus.rem     = rem_q[HalfW:0];

`ifdef SQRT_ROUND_NEAREST_EN
    logic round_up;
    assign round_up = (rem_q[HalfW:0] > {1'b0, root_q}) && !(&root_q);
    assign bus.res  = root_q + HalfW'(round_up);
`else
    assign bus.res  = root_q;
`endif

endmodule

// File: tb/tb_sqrt_multi_cycle_hs.sv
// Randomised and directed self-checking bench for sqrt_multi_cycle_hs at DATA_WIDTH=8.
// Expected results come from a plain-arithmetic square-root model.
module tb_sqrt_multi_cycle_hs;
    localparam int unsigned DW = 8;
    localparam int unsigned HW = DW / 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   last_acc;

    sqrt_multi_cycle_hs_if #(.DATA_WIDTH(DW)) bus ();

    sqrt_multi_cycle_hs #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Floor root by search; optional round-to-nearest applied to the root only.
    function automatic void model(input int a, output int r, output int m);
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        m = a - r * r;
`ifdef SQRT_ROUND_NEAREST_EN
        if ((m > r) && (r < (1 << HW) - 1)) r++;
`endif
    endfunction

    task automatic run_op(input int a, input int hold, input bit keep_vld);
        int er, em, lat, bad, t_acc;
        model(a, er, em);
        lat = 0;
        while (!bus.arg_rdy && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rdy_before_accept", bus.arg_rdy, 1);
        bus.arg     = DW'(a);
        bus.arg_vld = 1'b1;
        bus.res_rdy = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc;
        check("busy_after_accept", bus.busy, 1);
        if (keep_vld && last_acc >= 0) check("throughput", t_acc - last_acc, HW + 2);
        last_acc = keep_vld ? t_acc : -1;
        if (!keep_vld) bus.arg_vld = 1'b0;
        bus.arg = DW'($urandom);
        lat = 0;
        bad = 0;
        while (!bus.res_vld && lat < 50) begin
            if (bus.arg_rdy || !bus.busy) bad++;
            @(posedge clk); #1;
            bus.arg = DW'($urandom);
            lat++;
        end
        check("rdy_low_in_calc", bad, 0);
        check("latency", lat, HW);
        check("res", bus.res, er);
        check("rem", bus.rem, em);
        if (hold > 0) begin
            bus.res_rdy = 1'b0;
            bus.arg_vld = 1'b1;
            bad = 0;
            repeat (hold) begin
                bus.arg = DW'($urandom);
                @(posedge clk); #1;
                if (!bus.res_vld || bus.arg_rdy || !bus.busy) bad++;
                if (bus.res !== HW'(er) || bus.rem !== (HW + 1)'(em)) bad++;
            end
            check("hold_stable", bad, 0);
            bus.res_rdy = 1'b1;
        end
        @(posedge clk); #1;
        bus.arg_vld = keep_vld;
        check("idle_after_hs_rdy", bus.arg_rdy, 1);
        check("idle_after_hs_vld", bus.res_vld, 0);
    endtask

    initial begin
        int bad;
        n_checks    = 0;
        n_errors    = 0;
        cyc         = 0;
        last_acc    = -1;
        rst_n       = 1'b0;
        bus.arg_vld = 1'b0;
        bus.arg     = '0;
        bus.res_rdy = 1'b1;

        @(negedge clk);
        check("rst_res_vld", bus.res_vld, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_res", bus.res, 0);
        check("rst_rem", bus.rem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_arg_rdy", bus.arg_rdy, 1);

        // Directed: small value, perfect square, both extremes.
        run_op(3, 0, 0);
        run_op(144, 0, 0);
        run_op(0, 0, 0);
        run_op(255, 0, 0);

        // Exhaustive back-to-back with arg_vld held high.
        last_acc = -1;
        for (int i = 0; i < (1 << DW); i++) run_op(i, 0, 1);
        bus.arg_vld = 1'b0;
        last_acc    = -1;

        // Back-pressure with a new arg offered while the result is held.
        run_op(200, 10, 0);

        // Randomised values and back-pressure lengths.
        repeat (40) run_op(int'($urandom_range(0, (1 << DW) - 1)), int'($urandom_range(0, 3)), 0);

        // Reset in the middle of a calculation.
        bus.arg     = DW'(99);
        bus.arg_vld = 1'b1;
        @(posedge clk); #1;
        bus.arg_vld = 1'b0;
        check("mid_rst_accepted", bus.busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_vld", bus.res_vld, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_res", bus.res, 0);
        check("mid_rst_rem", bus.rem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.res_vld || bus.busy) bad++;
        end
        check("no_vld_after_rst", bad, 0);
        run_op(99, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
